// File: rtl/lsu_master.sv
// Load/store initiator for a word-wide, byte-addressed, big-endian data memory.
// Define LSU_ALIGN_CHECK_EN to reject misaligned halfword/word accesses.
module lsu_master #(
  parameter int addresswidth = 28,
  parameter int width        = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [1:0]              req_size,
  input  logic                    req_signed,
  input  logic [addresswidth-1:0] req_addr,
  input  logic [width-1:0]        req_wdata,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [width-1:0]        resp_rdata,
  output logic                    resp_error,
  output logic [addresswidth-1:0] mem_address,
  output logic                    mem_writeEnable,
  output logic [width-1:0]        mem_dataIn,
  input  logic [width-1:0]        mem_dataOut
);

`ifdef LSU_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP} state_t;

  state_t            state;
  logic [1:0]        size;
  logic              sgn;
  logic [width-1:0]  wdata;
  logic              we;

  function automatic logic illegal(input logic [1:0] sz, input logic [1:0] lsb);
    logic misaligned;
    misaligned = (sz == 2'b01 && lsb[0]) || (sz == 2'b10 && lsb != 2'b00);
    return (sz == 2'b11) || (ALIGN_CHECK && misaligned);
  endfunction

  // The addressed byte sits in the most significant lane of the word.
  function automatic logic [width-1:0] extend(input logic [width-1:0] word,
                                              input logic [1:0] sz, input logic sg);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = word[width-1 -: 8];
    h = word[width-1 -: 16];
    case (sz)
      2'b00:   return sg ? width'(b) : {{(width-8){1'b0}}, b};
      2'b01:   return sg ? width'(h) : {{(width-16){1'b0}}, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [width-1:0] merge(input logic [width-1:0] sample,
                                             input logic [width-1:0] wd, input logic [1:0] sz);
    if (sz == 2'b00) return {wd[7:0], sample[width-9:0]};
    return {wd[15:0], sample[width-17:0]};
  endfunction

  assign mem_writeEnable = we && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_error  <= 1'b0;
      mem_address <= '0;
      mem_dataIn  <= '0;
      we          <= 1'b0;
      size        <= 2'b00;
      sgn         <= 1'b0;
      wdata       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            size      <= req_size;
            sgn       <= req_signed;
            wdata     <= req_wdata;
            // Rejected requests leave every memory-side output untouched.
            if (illegal(req_size, req_addr[1:0])) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= '0;
            end else begin
              mem_address <= req_addr;
              if (!req_write) begin
                state <= LOAD;
              end else if (req_size == 2'b10) begin
                state      <= STORE;
                we         <= 1'b1;
                mem_dataIn <= req_wdata;
              end else begin
                state <= RMW_RD;
              end
            end
          end
        end
        LOAD: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_error <= 1'b0;
          resp_rdata <= extend(mem_dataOut, size, sgn);
        end
        RMW_RD: begin
          state      <= RMW_WR;
          we         <= 1'b1;
          mem_dataIn <= merge(mem_dataOut, wdata, size);
        end
        STORE, RMW_WR: begin
          state      <= RESP;
          we         <= 1'b0;
          mem_dataIn <= '0;
          resp_valid <= 1'b1;
          resp_error <= 1'b0;
          resp_rdata <= '0;
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            resp_rdata <= '0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_master.sv
// Self-checking bench for lsu_master: byte-array memory plus a byte-level reference model.
module tb_lsu_master;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [27:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [27:0] mem_address;
  logic        mem_writeEnable;
  logic [31:0] mem_dataIn;
  logic [31:0] mem_dataOut;

  int n_cmp = 0;
  int n_fail = 0;

`ifdef LSU_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  always #5 clk = ~clk;

  lsu_master #(.addresswidth(28), .width(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_error(resp_error),
    .mem_address(mem_address), .mem_writeEnable(mem_writeEnable),
    .mem_dataIn(mem_dataIn), .mem_dataOut(mem_dataOut)
  );

  // 256-byte memory, big-endian, wrapping within the array
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic [7:0] a0;
  assign a0 = mem_address[7:0];
  always_comb mem_dataOut = {mem[a0], mem[a0 + 8'd1], mem[a0 + 8'd2], mem[a0 + 8'd3]};
  always @(posedge clk)
    if (mem_writeEnable) begin
      mem[a0]         <= mem_dataIn[31:24];
      mem[a0 + 8'd1]  <= mem_dataIn[23:16];
      mem[a0 + 8'd2]  <= mem_dataIn[15:8];
      mem[a0 + 8'd3]  <= mem_dataIn[7:0];
    end

  task automatic set_byte(input int a, input logic [7:0] v);
    mem[a % 256] = v;
    ref_mem[a % 256] = v;
  endtask

  function automatic bit model_illegal(input int a, input int sz);
    if (sz == 3) return 1'b1;
    return ALIGN && ((a % (1 << sz)) != 0);
  endfunction

  function automatic logic [31:0] model_load(input int a, input int sz, input bit sg);
    longint v;
    int n;
    n = 1 << sz;
    v = 0;
    for (int i = 0; i < n; i++) v = (v << 8) | ref_mem[(a + i) % 256];
    if (sg && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic model_store(input int a, input int sz, input logic [31:0] wd);
    int n;
    n = 1 << sz;
    for (int i = 0; i < n; i++) ref_mem[(a + i) % 256] = 8'(wd >> (8 * (n - 1 - i)));
  endtask

  // Issues one request, returns response, latency (edges after acceptance) and write-strobe count.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg, input int a,
                        input logic [31:0] wd, input int hold,
                        output logic [31:0] rd, output logic err, output int lat, output int wes);
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL req_ready_idle: got %b, expected 1", req_ready);
    end
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = 28'(a); req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; wes = 0; rd = '0; err = 1'b0;
    @(negedge clk);
    while (!resp_valid && lat < 20) begin
      if (mem_writeEnable) wes++;
      @(negedge clk);
      lat++;
    end
    if (!resp_valid) begin
      n_cmp++; n_fail++;
      $display("FAIL resp_timeout: resp_valid=%b after %0d cycles, expected 1", resp_valid, lat);
      return;
    end
    rd = resp_rdata;
    err = resp_error;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      n_cmp++;
      if (resp_valid !== 1'b1 || resp_rdata !== rd || resp_error !== err || req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_stable[%0d]: valid=%b rdata=%h err=%b req_ready=%b, expected 1 %h %b 0",
                 k, resp_valid, resp_rdata, resp_error, req_ready, rd, err);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_error !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_resp: ready=%b valid=%b rdata=%h err=%b, expected 1 0 0 0",
               req_ready, resp_valid, resp_rdata, resp_error);
    end
    n_cmp++;
    if (mem_address !== 28'h0 || mem_writeEnable !== 1'b0 || mem_dataIn !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mem: addr=%h we=%b din=%h, expected 0 0 0",
               mem_address, mem_writeEnable, mem_dataIn);
    end
    reset = 1'b0;
  endtask

  task automatic test_loads;
    logic [31:0] rd; logic err; int lat, wes;
    set_byte(16'h10, 8'h11); set_byte(16'h11, 8'h22); set_byte(16'h12, 8'h33); set_byte(16'h13, 8'h44);
    do_req(1'b0, 2'b10, 1'b0, 'h10, 32'h0, 0, rd, err, lat, wes);
    n_cmp++;
    if (rd !== 32'h11223344 || err !== 1'b0) begin
      n_fail++; $display("FAIL word_load: rdata=%h err=%b, expected 11223344 0", rd, err);
    end
    n_cmp++;
    if (lat !== 1 || wes !== 0) begin
      n_fail++; $display("FAIL word_load_timing: lat=%0d we=%0d, expected 1 0", lat, wes);
    end
    set_byte(16'h10, 8'h9A);
    do_req(1'b0, 2'b00, 1'b1, 'h10, 32'h0, 0, rd, err, lat, wes);
    n_cmp++;
    if (rd !== 32'hFFFFFF9A) begin
      n_fail++; $display("FAIL byte_load_signed: rdata=%h, expected ffffff9a", rd);
    end
    do_req(1'b0, 2'b00, 1'b0, 'h10, 32'h0, 0, rd, err, lat, wes);
    n_cmp++;
    if (rd !== 32'h0000009A) begin
      n_fail++; $display("FAIL byte_load_unsigned: rdata=%h, expected 0000009a", rd);
    end
    set_byte(16'h12, 8'h80); set_byte(16'h13, 8'h01);
    do_req(1'b0, 2'b01, 1'b1, 'h12, 32'h0, 0, rd, err, lat, wes);
    n_cmp++;
    if (rd !== 32'hFFFF8001) begin
      n_fail++; $display("FAIL half_load_signed: rdata=%h, expected ffff8001", rd);
    end
    do_req(1'b0, 2'b01, 1'b0, 'h12, 32'h0, 0, rd, err, lat, wes);
    n_cmp++;
    if (rd !== 32'h00008001) begin
      n_fail++; $display("FAIL half_load_unsigned: rdata=%h, expected 00008001", rd);
    end
  endtask

  task automatic test_byte_store;
    logic [31:0] rd; logic err; int lat, wes;
    set_byte(16'h20, 8'hAA); set_byte(16'h21, 8'hBB); set_byte(16'h22, 8'hCC);
    set_byte(16'h23, 8'hDD); set_byte(16'h24, 8'h77);
    do_req(1'b1, 2'b00, 1'b0, 'h21, 32'h1234565E, 0, rd, err, lat, wes);
    n_cmp++;
    if ({mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23], mem[8'h24]} !== 40'hAA5ECCDD77) begin
      n_fail++;
      $display("FAIL byte_store_mem: %h %h %h %h %h, expected aa 5e cc dd 77",
               mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23], mem[8'h24]);
    end
    n_cmp++;
    if (lat !== 2 || wes !== 1 || rd !== 32'h0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL byte_store_resp: lat=%0d we=%0d rdata=%h err=%b, expected 2 1 0 0", lat, wes, rd, err);
    end
    model_store('h21, 0, 32'h1234565E);
    do_req(1'b1, 2'b01, 1'b0, 'h22, 32'hFFFF0102, 0, rd, err, lat, wes);
    model_store('h22, 1, 32'hFFFF0102);
    n_cmp++;
    if ({mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23], mem[8'h24]} !== 40'hAA5E010277 || lat !== 2) begin
      n_fail++;
      $display("FAIL half_store_mem: %h %h %h %h %h lat=%0d, expected aa 5e 01 02 77 lat 2",
               mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23], mem[8'h24], lat);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd; logic err; int lat, wes;
    do_req(1'b1, 2'b10, 1'b0, 'h40, 32'hDEADBEEF, 0, rd, err, lat, wes);
    model_store('h40, 2, 32'hDEADBEEF);
    n_cmp++;
    if (lat !== 1 || wes !== 1) begin
      n_fail++; $display("FAIL word_store_timing: lat=%0d we=%0d, expected 1 1", lat, wes);
    end
    do_req(1'b0, 2'b10, 1'b0, 'h40, 32'h0, 3, rd, err, lat, wes);
    n_cmp++;
    if (rd !== 32'hDEADBEEF || err !== 1'b0) begin
      n_fail++; $display("FAIL word_readback: rdata=%h err=%b, expected deadbeef 0", rd, err);
    end
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic err; int lat, wes;
    logic [27:0] addr_before;
    logic [31:0] exp;
    addr_before = mem_address;
    do_req(1'b1, 2'b11, 1'b0, 'h50, 32'hFFFFFFFF, 0, rd, err, lat, wes);
    n_cmp++;
    if (err !== 1'b1 || rd !== 32'h0 || wes !== 0 || mem_address !== addr_before) begin
      n_fail++;
      $display("FAIL size11_error: err=%b rdata=%h we=%0d addr=%h, expected 1 0 0 %h",
               err, rd, wes, mem_address, addr_before);
    end
    for (int i = 0; i < 4; i++) set_byte('h42 + i, 8'(8'hC0 + i));
    addr_before = mem_address;
    do_req(1'b0, 2'b10, 1'b0, 'h42, 32'h0, 0, rd, err, lat, wes);
    exp = ALIGN ? 32'h0 : 32'hC0C1C2C3;
    n_cmp++;
    if (err !== ALIGN || rd !== exp || wes !== 0) begin
      n_fail++;
      $display("FAIL misaligned_word: err=%b rdata=%h we=%0d, expected %b %h 0", err, rd, wes, ALIGN, exp);
    end
    n_cmp++;
    if (ALIGN && mem_address !== addr_before) begin
      n_fail++; $display("FAIL misaligned_addr: addr=%h, expected %h", mem_address, addr_before);
    end
  endtask

  task automatic test_random;
    logic [31:0] rd, exp; logic err; int lat, wes, bad, exp_lat, exp_wes;
    logic w; logic [1:0] sz; logic sg; int a; logic [31:0] wd; bit ill;
    for (int i = 0; i < 256; i++) set_byte(i, 8'($urandom));
    for (int t = 0; t < 60; t++) begin
      w = 1'($urandom); sz = 2'($urandom); sg = 1'($urandom);
      a = $urandom_range(0, 255); wd = $urandom;
      ill = model_illegal(a, sz);
      exp = (ill || w) ? 32'h0 : model_load(a, sz, sg);
      exp_wes = (w && !ill) ? 1 : 0;
      exp_lat = (!ill && w && sz != 2'b10) ? 2 : 1;
      do_req(w, sz, sg, a, wd, $urandom_range(0, 2), rd, err, lat, wes);
      if (w && !ill) model_store(a, sz, wd);
      n_cmp++;
      if (rd !== exp || err !== ill || wes !== exp_wes || (!ill && lat !== exp_lat)) begin
        n_fail++;
        $display("FAIL rand[%0d] w=%b sz=%0d sg=%b a=%h: rdata=%h err=%b we=%0d lat=%0d, expected %h %b %0d %0d",
                 t, w, sz, sg, a, rd, err, wes, lat, exp, ill, exp_wes, exp_lat);
      end
    end
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    n_cmp++;
    if (bad != 0) begin
      n_fail++; $display("FAIL rand_mem_image: %0d bytes differ, expected 0", bad);
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    for (int i = 0; i < 4; i++) set_byte('h30 + i, 8'(8'h50 + i));
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 28'h30; req_wdata = 32'h000000EE;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (mem_writeEnable !== 1'b1) begin
      n_fail++; $display("FAIL rmw_wr_strobe: we=%b, expected 1", mem_writeEnable);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (mem_writeEnable !== 1'b0) begin
      n_fail++; $display("FAIL reset_gates_we: we=%b, expected 0", mem_writeEnable);
    end
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_error !== 1'b0 ||
        mem_address !== 28'h0 || mem_writeEnable !== 1'b0 || mem_dataIn !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: ready=%b valid=%b rdata=%h err=%b addr=%h we=%b din=%h, expected reset values",
               req_ready, resp_valid, resp_rdata, resp_error, mem_address, mem_writeEnable, mem_dataIn);
    end
    n_cmp++;
    if ({mem[8'h30], mem[8'h31], mem[8'h32], mem[8'h33]} !== 32'h50515253) begin
      n_fail++;
      $display("FAIL reset_mid_mem: %h%h%h%h, expected 50515253",
               mem[8'h30], mem[8'h31], mem[8'h32], mem[8'h33]);
    end
    reset = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_fail++; $display("FAIL reset_mid_no_resp: resp_valid seen %0d cycles, expected 0", seen);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) set_byte(i, 8'h00);
    test_reset();
    test_loads();
    test_byte_store();
    test_back_to_back();
    test_errors();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
